sync_fifo_ext: RTL and testbench

Parametrised single-clock FIFO, successor to the basic sync FIFO.
- Adds configurable depth and width with correctly sized pointers and count, and almost-full/almost-empty thresholds.
- Adds sticky-free overflow/underflow error pulses and a first-word-fall-through (FWFT) read mode.
- Sits between producer/consumer stages in the datapath as the standard buffering primitive.

---
 rtl/sync_fifo_pkg.sv | 33 +++
 rtl/fifo_mem_2p.sv | 38 +++
 rtl/sync_fifo_ext.sv | 148 ++++++++++++++
 tb/tb_sync_fifo_ext.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_pkg
// Purpose  : Shared sizing helpers and default thresholds for sync_fifo_ext
//            and its storage sub-module.
// Contents : ptr_w()   - pointer width for a given depth
//            cnt_w()   - occupancy counter width (holds 0..DEPTH)
//            is_pow2() - power-of-two test used by elaboration checks
//            DEF_*     - default depth and threshold constants
// Revision : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

  localparam int DEF_DEPTH     = 16;
  localparam int DEF_AE_THRESH = 2;
  // almost_full default sits this many entries below DEPTH
  localparam int DEF_AF_MARGIN = 2;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so the counter can represent DEPTH itself
  function automatic int cnt_w(input int depth);
    return ptr_w(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem_2p.sv
`default_nettype none
// ============================================================================
// Module   : fifo_mem_2p
// Purpose  : Register-array storage, one synchronous write port and one
//            asynchronous (combinational) read port. Contents are not reset.
// Ports    : clk        - write clock
//            wr_en_i    - write strobe
//            wr_addr_i  - write address
//            wr_data_i  - write data
//            rd_addr_i  - read address
//            rd_data_o  - read data (combinational from rd_addr_i)
// Revision : 1.0 - initial release
// ============================================================================
module fifo_mem_2p #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [ADDR_W-1:0]     rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_ext.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_ext
// Purpose  : Parametrised single-clock FIFO with almost-full/almost-empty
//            thresholds, overflow/underflow pulses and optional
//            first-word-fall-through read mode.
// Ports    : clk              - rising-edge clock
//            rst              - asynchronous active-high reset
//            wr_en_i/data_in_i- write request / data
//            rd_en_i          - read request (FWFT: pop of head word)
//            data_out_o       - read data
//            full_o/empty_o   - occupancy == DEPTH / == 0
//            almost_full_o    - count >= AF_THRESH
//            almost_empty_o   - count <= AE_THRESH
//            count_o          - occupancy 0..DEPTH
//            overflow_o       - one-cycle pulse after a write while full
//            underflow_o      - one-cycle pulse after a read while empty
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_ext
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AF_THRESH  = DEPTH - DEF_AF_MARGIN,
  parameter int AE_THRESH  = DEF_AE_THRESH,
  parameter int FWFT       = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en_i,
  input  logic [DATA_WIDTH-1:0]     data_in_i,
  input  logic                      rd_en_i,
  output logic [DATA_WIDTH-1:0]     data_out_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic                      almost_full_o,
  output logic                      almost_empty_o,
  output logic [cnt_w(DEPTH)-1:0]   count_o,
  output logic                      overflow_o,
  output logic                      underflow_o
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

  // Parameter sanity: abort elaboration on illegal configurations
  if (DATA_WIDTH < 1) begin : g_chk_width
    $fatal(1, "sync_fifo_ext: DATA_WIDTH must be >= 1");
  end
  if ((DEPTH < 2) || !is_pow2(DEPTH)) begin : g_chk_depth
    $fatal(1, "sync_fifo_ext: DEPTH must be a power of two >= 2");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_chk_af
    $fatal(1, "sync_fifo_ext: AF_THRESH must be in 1..DEPTH");
  end
  if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_chk_ae
    $fatal(1, "sync_fifo_ext: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_q, empty_q, afull_q, aempty_q;
  logic                  ovf_q, unf_q;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] mem_rd;

  // Acceptance uses the registered flags, so a full FIFO still takes a
  // read and an empty one still takes a write on the same edge.
  assign wr_acc = wr_en_i & ~full_q;
  assign rd_acc = rd_en_i & ~empty_q;

  always_comb begin
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Flags are derived from count_d so they are valid right after the edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      empty_q  <= (count_d == '0);
      afull_q  <= (count_d >= AF_C);
      aempty_q <= (count_d <= AE_C);
      ovf_q    <= wr_en_i & full_q;
      unf_q    <= rd_en_i & empty_q;
    end
  end

  fifo_mem_2p #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (PTR_W)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (data_in_i),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (mem_rd)
  );

  if (FWFT != 0) begin : g_fwft
    // Head word is shown directly; zero while nothing valid is stored
    assign data_out_o = empty_q ? '0 : mem_rd;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= '0;
      end else if (rd_acc) begin
        dout_q <= mem_rd;
      end
    end
    assign data_out_o = dout_q;
  end

  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;
  assign count_o        = count_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_ext.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_ext
// Purpose  : Self-checking bench for sync_fifo_ext, one standard-mode and
//            one FWFT instance (DEPTH=16, DATA_WIDTH=8, default thresholds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_ext;

  logic       clk = 1'b0;
  logic       rst;
  // standard-mode instance
  logic       wr_en, rd_en;
  logic [7:0] din, dout;
  logic       full, empty, af, ae, ovf, unf;
  logic [4:0] cnt;
  // FWFT instance
  logic       wr_f, rd_f;
  logic [7:0] din_f, dout_f;
  logic       full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
  logic [4:0] cnt_f;

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard / reference model for the standard instance
  logic [7:0] sb[$];
  logic [7:0] exp_dout;
  bit         exp_ovf, exp_unf;

  always #5 clk = ~clk;

  sync_fifo_ext #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) dut (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .data_in_i(din), .rd_en_i(rd_en),
    .data_out_o(dout), .full_o(full), .empty_o(empty), .almost_full_o(af),
    .almost_empty_o(ae), .count_o(cnt), .overflow_o(ovf), .underflow_o(unf)
  );

  sync_fifo_ext #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1)) dut_fw (
    .clk(clk), .rst(rst), .wr_en_i(wr_f), .data_in_i(din_f), .rd_en_i(rd_f),
    .data_out_o(dout_f), .full_o(full_f), .empty_o(empty_f), .almost_full_o(af_f),
    .almost_empty_o(ae_f), .count_o(cnt_f), .overflow_o(ovf_f), .underflow_o(unf_f)
  );

  // One clock of stimulus on the standard instance; updates the model.
  // Entered and left at 1 time unit after a rising edge.
  task automatic step(input bit w, input logic [7:0] d, input bit r);
    bit full_m, empty_m;
    full_m  = (sb.size() == 16);
    empty_m = (sb.size() == 0);
    exp_ovf = w && full_m;
    exp_unf = r && empty_m;
    if (r && !empty_m) exp_dout = sb.pop_front();
    if (w && !full_m)  sb.push_back(d);
    wr_en = w; din = d; rd_en = r;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    exp_dout = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_tests++; if (ae !== 1'b1)    begin n_fail++; $display("FAIL reset_ae: got %b want 1", ae); end
    n_tests++; if (full !== 1'b0 || af !== 1'b0) begin n_fail++; $display("FAIL reset_full_af: got %b%b want 00", full, af); end
    n_tests++; if (cnt !== 5'd0)   begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
    n_tests++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout); end
    n_tests++; if (ovf !== 1'b0 || unf !== 1'b0) begin n_fail++; $display("FAIL reset_err: got ovf=%b unf=%b want 0 0", ovf, unf); end
    n_tests++; if (dout_f !== 8'h00 || empty_f !== 1'b1) begin n_fail++; $display("FAIL reset_fwft: got dout=%h empty=%b want 00 1", dout_f, empty_f); end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b0);
      n_tests++; if (cnt !== 5'(i)) begin n_fail++; $display("FAIL fill_cnt[%0d]: got %0d want %0d", i, cnt, i); end
      n_tests++; if (af !== (i >= 14)) begin n_fail++; $display("FAIL fill_af[%0d]: got %b want %b", i, af, (i >= 14)); end
      n_tests++; if (full !== (i == 16)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b want %b", i, full, (i == 16)); end
      n_tests++; if (ae !== (i <= 2)) begin n_fail++; $display("FAIL fill_ae[%0d]: got %b want %b", i, ae, (i <= 2)); end
    end
    step(1'b1, 8'hAA, 1'b0);
    n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse: got %b want 1", ovf); end
    n_tests++; if (cnt !== 5'd16) begin n_fail++; $display("FAIL ovf_cnt: got %0d want 16", cnt); end
    step(1'b0, 8'h00, 1'b0);
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", ovf); end
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 8'h00, 1'b1);
      n_tests++; if (dout !== 8'(i)) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", i, dout, 8'(i)); end
      n_tests++; if (cnt !== 5'(16 - i)) begin n_fail++; $display("FAIL drain_cnt[%0d]: got %0d want %0d", i, cnt, 16 - i); end
    end
    n_tests++; if (empty !== 1'b1 || unf !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got empty=%b unf=%b want 1 0", empty, unf); end
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) step(1'b1, 8'(r * 10 + i), 1'b0);
      for (int i = 0; i < 10; i++) begin
        step(1'b0, 8'h00, 1'b1);
        n_tests++; if (dout !== 8'(r * 10 + i)) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h want %h", r * 10 + i, dout, 8'(r * 10 + i)); end
      end
      n_tests++; if (cnt !== 5'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL wrap_cnt[%0d]: got cnt=%0d empty=%b want 0 1", r, cnt, empty); end
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    step(1'b1, 8'h77, 1'b1);
    n_tests++; if (cnt !== 5'd15) begin n_fail++; $display("FAIL full_both_cnt: got %0d want 15", cnt); end
    n_tests++; if (ovf !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL full_both_flags: got ovf=%b full=%b want 1 0", ovf, full); end
    n_tests++; if (dout !== 8'h40) begin n_fail++; $display("FAIL full_both_data: got %h want 40", dout); end
    for (int i = 1; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1);
      n_tests++; if (dout !== exp_dout) begin n_fail++; $display("FAIL full_drain[%0d]: got %h want %h", i, dout, exp_dout); end
    end
    step(1'b1, 8'h33, 1'b1);
    n_tests++; if (cnt !== 5'd1 || empty !== 1'b0) begin n_fail++; $display("FAIL empty_both: got cnt=%0d empty=%b want 1 0", cnt, empty); end
    n_tests++; if (unf !== 1'b1 || ovf !== 1'b0) begin n_fail++; $display("FAIL empty_both_err: got unf=%b ovf=%b want 1 0", unf, ovf); end
    step(1'b0, 8'h00, 1'b1);
    n_tests++; if (dout !== 8'h33) begin n_fail++; $display("FAIL empty_both_data: got %h want 33", dout); end
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(8'hA0 + i), 1'b1);
      n_tests++; if (cnt !== 5'd8) begin n_fail++; $display("FAIL mid_both_cnt[%0d]: got %0d want 8", i, cnt); end
      n_tests++; if (dout !== exp_dout) begin n_fail++; $display("FAIL mid_both_data[%0d]: got %h want %h", i, dout, exp_dout); end
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1);
      n_tests++; if (dout !== exp_dout) begin n_fail++; $display("FAIL mid_drain[%0d]: got %h want %h", i, dout, exp_dout); end
    end
  endtask

  task automatic test_underflow_hold();
    logic [7:0] held;
    held = exp_dout;
    step(1'b0, 8'h00, 1'b1);
    n_tests++; if (unf !== exp_unf || unf !== 1'b1) begin n_fail++; $display("FAIL unf_pulse: got %b want 1", unf); end
    n_tests++; if (dout !== held) begin n_fail++; $display("FAIL unf_hold: got %h want %h", dout, held); end
    n_tests++; if (cnt !== 5'd0) begin n_fail++; $display("FAIL unf_cnt: got %0d want 0", cnt); end
    step(1'b0, 8'h00, 1'b0);
    n_tests++; if (unf !== 1'b0) begin n_fail++; $display("FAIL unf_clear: got %b want 0", unf); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    wr_en = 1'b1; din = 8'hEE;
    #2;
    rst = 1'b1;
    #1;
    n_tests++; if (cnt !== 5'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL async_rst: got cnt=%0d empty=%b want 0 1", cnt, empty); end
    n_tests++; if (dout !== 8'h00 || ae !== 1'b1) begin n_fail++; $display("FAIL async_rst_dout: got dout=%h ae=%b want 00 1", dout, ae); end
    wr_en = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    sb.delete();
    exp_dout = 8'h00;
    @(posedge clk); #1;
    n_tests++; if (cnt !== 5'd0 || dout !== 8'h00) begin n_fail++; $display("FAIL post_rst: got cnt=%0d dout=%h want 0 00", cnt, dout); end
  endtask

  task automatic test_fwft();
    n_tests++; if (dout_f !== 8'h00 || empty_f !== 1'b1) begin n_fail++; $display("FAIL fwft_idle: got dout=%h empty=%b want 00 1", dout_f, empty_f); end
    wr_f = 1'b1; din_f = 8'h5A;
    @(posedge clk); #1;
    din_f = 8'h6B;
    n_tests++; if (dout_f !== 8'h5A || empty_f !== 1'b0) begin n_fail++; $display("FAIL fwft_first: got dout=%h empty=%b want 5a 0", dout_f, empty_f); end
    @(posedge clk); #1;
    wr_f = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (dout_f !== 8'h5A || cnt_f !== 5'd2) begin n_fail++; $display("FAIL fwft_hold: got dout=%h cnt=%0d want 5a 2", dout_f, cnt_f); end
    rd_f = 1'b1;
    @(posedge clk); #1;
    rd_f = 1'b0;
    n_tests++; if (dout_f !== 8'h6B || cnt_f !== 5'd1) begin n_fail++; $display("FAIL fwft_pop1: got dout=%h cnt=%0d want 6b 1", dout_f, cnt_f); end
    rd_f = 1'b1;
    @(posedge clk); #1;
    rd_f = 1'b0;
    n_tests++; if (dout_f !== 8'h00 || empty_f !== 1'b1) begin n_fail++; $display("FAIL fwft_pop2: got dout=%h empty=%b want 00 1", dout_f, empty_f); end
    rd_f = 1'b1;
    @(posedge clk); #1;
    rd_f = 1'b0;
    n_tests++; if (unf_f !== 1'b1 || dout_f !== 8'h00) begin n_fail++; $display("FAIL fwft_unf: got unf=%b dout=%h want 1 00", unf_f, dout_f); end
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
    wr_f = 1'b0; rd_f = 1'b0; din_f = 8'h00;
    exp_dout = 8'h00; exp_ovf = 1'b0; exp_unf = 1'b0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_underflow_hold();
    test_async_reset();
    test_fwft();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
